// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: per-stage payload layouts, stall-counter default
// and the encoding of the skid-buffer occupancy state.
package pipe_stage_reg_pkg;

    localparam int NPCOP_W       = 2;
    localparam int STALL_CNT_W   = 16;
    localparam int XLEN          = 32;
    localparam int REG_IDX_W     = 5;
    localparam int ALU_OP_W      = 4;

    // Occupancy encoded as {main valid, skid valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } skid_state_e;

    typedef enum logic [NPCOP_W-1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JAL    = 2'd2,
        NPC_JALR   = 2'd3
    } npc_op_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_val;
        logic [XLEN-1:0]      rs2_val;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rd;
        logic [ALU_OP_W-1:0]  alu_op;
        npc_op_e              npc_op;
        logic                 alu_src_imm;
        logic                 mem_we;
        logic                 mem_re;
        logic                 reg_we;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      alu_res;
        logic [XLEN-1:0]      store_data;
        logic [REG_IDX_W-1:0] rd;
        logic                 mem_we;
        logic                 mem_re;
        logic                 reg_we;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      wb_data;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_we;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: valid/ready handshake, synchronous flush,
// optional two-entry skid buffer (registered in_ready) and a stall counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = STALL_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            skid_state_e       state_q, state_d;
            logic [DATA_W-1:0] main_q, main_d;
            logic [DATA_W-1:0] skid_q, skid_d;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (in_xfer) begin
                            state_d = ST_ONE;
                            main_d  = in_data;
                        end
                    end
                    ST_ONE: begin
                        if (in_xfer && !out_xfer) begin
                            state_d = ST_TWO;
                            skid_d  = in_data;
                        end else if (!in_xfer && out_xfer) begin
                            state_d = ST_EMPTY;
                        end else if (in_xfer && out_xfer) begin
                            main_d  = in_data;
                        end
                    end
                    ST_TWO: begin
                        if (out_xfer) begin
                            state_d = ST_ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
                // Squash drops every held entry and whatever was accepted this cycle.
                if (flush) begin
                    state_d = ST_EMPTY;
                    main_d  = main_q;
                    skid_d  = skid_q;
                end
            end

            assign in_ready  = ~state_q[0];
            assign out_valid = state_q[1];
            assign out_data  = main_q;
        end else begin : g_noskid
            logic              valid_q;
            logic [DATA_W-1:0] data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (in_xfer) begin
                    valid_q <= 1'b1;
                    data_q  <= in_data;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                end
            end

            assign in_ready  = ~valid_q | out_ready;
            assign out_valid = valid_q;
            assign out_data  = data_q;
        end
    endgenerate

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(out_valid & ~out_ready),
        .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: skid variant, non-skid variant and a 4-bit counter variant.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // m_: SKID=1 main instance, z_: SKID=0, s_: SKID=1 with 4-bit counter
    logic        m_flush, m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [31:0] m_in_data, m_out_data;
    logic [15:0] m_stall_cnt;
    logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [31:0] z_in_data, z_out_data;
    logic [15:0] z_stall_cnt;
    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_data, s_out_data;
    logic [3:0]  s_stall_cnt;

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) u_m (
        .clk(clk), .rst(rst), .flush(m_flush),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
        .stall_cnt(m_stall_cnt));

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_z (
        .clk(clk), .rst(rst), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .stall_cnt(z_stall_cnt));

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) u_s (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt));

    int checks   = 0;
    int failures = 0;
    logic [31:0] mq[$];
    logic [31:0] zq[$];
    logic [31:0] m_exp, z_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every output transfer must match the head of its queue.
    always @(negedge clk) begin
        if (!rst && m_out_valid && m_out_ready) begin
            checks++;
            if (mq.size() == 0) begin
                failures++;
                $display("FAIL m_unexpected actual=%h required=none", m_out_data);
            end else begin
                m_exp = mq.pop_front();
                if (m_out_data !== m_exp) begin
                    failures++;
                    $display("FAIL m_order actual=%h required=%h", m_out_data, m_exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && z_out_valid && z_out_ready) begin
            checks++;
            if (zq.size() == 0) begin
                failures++;
                $display("FAIL z_unexpected actual=%h required=none", z_out_data);
            end else begin
                z_exp = zq.pop_front();
                if (z_out_data !== z_exp) begin
                    failures++;
                    $display("FAIL z_order actual=%h required=%h", z_out_data, z_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zi;
        rst = 1'b1;
        m_flush = 0; m_in_valid = 1; m_in_data = 32'hDEADBEEF; m_out_ready = 0;
        z_flush = 0; z_in_valid = 1; z_in_data = 32'hDEADBEEF; z_out_ready = 0;
        s_flush = 0; s_in_valid = 0; s_in_data = 0;            s_out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0; m_in_valid = 0; m_in_data = 0; z_in_valid = 0; z_in_data = 0;

        // Reset values
        @(negedge clk);
        check("rst_out_valid", m_out_valid, 0);
        check("rst_out_data", m_out_data, 0);
        check("rst_in_ready", m_in_ready, 1);
        check("rst_stall_cnt", m_stall_cnt, 0);
        check("rst_z_in_ready", z_in_ready, 1);
        check("rst_z_out_data", z_out_data, 0);

        // Saturation with a 4-bit counter
        step();
        s_in_valid = 1; s_in_data = 32'd7;
        step();
        s_in_valid = 0;
        @(negedge clk);
        check("sat_out_valid", s_out_valid, 1);
        check("sat_cnt0", s_stall_cnt, 0);
        repeat (3) step();
        @(negedge clk);
        check("sat_cnt3", s_stall_cnt, 3);
        repeat (20) step();
        @(negedge clk);
        check("sat_cnt15", s_stall_cnt, 15);
        repeat (3) step();
        @(negedge clk);
        check("sat_hold", s_stall_cnt, 15);
        check("sat_data", s_out_data, 7);

        // Streaming 1..10 with out_ready held high
        step();
        m_out_ready = 1;
        for (int i = 1; i <= 10; i++) begin
            m_in_valid = 1; m_in_data = i;
            @(negedge clk);
            check("stream_in_ready", m_in_ready, 1);
            if (i > 1) begin
                check("stream_latency", m_out_data, i - 1);
                check("stream_out_valid", m_out_valid, 1);
            end
            mq.push_back(i);
            step();
        end
        m_in_valid = 0;
        @(negedge clk);
        check("stream_last", m_out_data, 10);
        check("stream_stall_cnt", m_stall_cnt, 0);
        step();

        // Back-pressure: A, B, C with out_ready low
        m_out_ready = 0;
        m_in_valid = 1; m_in_data = 32'hA;
        @(negedge clk);
        check("bp_rdy1", m_in_ready, 1);
        mq.push_back(32'hA);
        step();
        m_in_data = 32'hB;
        @(negedge clk);
        check("bp_rdy2", m_in_ready, 1);
        check("bp_head_a", m_out_data, 32'hA);
        mq.push_back(32'hB);
        step();
        m_in_data = 32'hC;
        @(negedge clk);
        check("bp_rdy3", m_in_ready, 0);
        check("bp_cnt1", m_stall_cnt, 1);
        step();
        @(negedge clk);
        check("bp_rdy4", m_in_ready, 0);
        check("bp_cnt2", m_stall_cnt, 2);
        step();
        @(negedge clk);
        check("bp_cnt3", m_stall_cnt, 3);
        step();
        m_out_ready = 1;
        @(negedge clk);
        check("bp_cnt4", m_stall_cnt, 4);
        check("bp_drain_rdy", m_in_ready, 0);
        check("bp_drain_a", m_out_data, 32'hA);
        step();
        @(negedge clk);
        check("bp_rdy_rise", m_in_ready, 1);
        check("bp_drain_b", m_out_data, 32'hB);
        mq.push_back(32'hC);
        step();
        m_in_valid = 0;
        @(negedge clk);
        check("bp_drain_c", m_out_data, 32'hC);
        check("bp_drain_c_vld", m_out_valid, 1);
        check("bp_cnt_final", m_stall_cnt, 4);
        step();

        // Flush in TWO with a pending input X
        m_out_ready = 0;
        m_in_valid = 1; m_in_data = 32'h0000_00A2;
        step();
        m_in_data = 32'h0000_00B2;
        step();
        m_in_data = 32'hBAD0BAD0; m_flush = 1;
        @(negedge clk);
        check("fl_pre_cnt", m_stall_cnt, 5);
        step();
        m_flush = 0; m_in_valid = 0;
        @(negedge clk);
        check("fl_out_valid", m_out_valid, 0);
        check("fl_in_ready", m_in_ready, 1);
        check("fl_cnt", m_stall_cnt, 6);
        m_out_ready = 1;
        step();
        m_in_valid = 1; m_in_data = 32'h1234;
        @(negedge clk);
        mq.push_back(32'h1234);
        step();
        m_in_valid = 0;
        step();

        // Flush in ONE: output delivered, simultaneous input discarded
        m_in_valid = 1; m_in_data = 32'hD1;
        @(negedge clk);
        mq.push_back(32'hD1);
        step();
        m_in_data = 32'hD2; m_flush = 1;
        step();
        m_flush = 0; m_in_valid = 0;
        @(negedge clk);
        check("fl1_out_valid", m_out_valid, 0);
        check("fl1_in_ready", m_in_ready, 1);
        step();

        // SKID=0: out_ready toggles every cycle while streaming
        zi = 0;
        for (int c = 0; c < 40 && zi < 8; c++) begin
            z_in_valid = 1; z_in_data = 32'h100 + zi;
            z_out_ready = (c % 2) == 1;
            @(negedge clk);
            check("z_in_ready", z_in_ready, !z_out_valid || z_out_ready);
            if (z_in_ready) begin
                zq.push_back(z_in_data);
                zi++;
            end
            step();
        end
        z_in_valid = 0;
        check("z_sent", zi, 8);
        z_out_ready = 1;
        for (int t = 0; t < 10 && zq.size() != 0; t++) step();
        check("z_drained", zq.size(), 0);

        // rst during a pending output cancels it
        m_out_ready = 0; m_in_valid = 1; m_in_data = 32'hE0;
        step();
        rst = 1; m_in_data = 32'hF0; m_out_ready = 1;
        step();
        rst = 0; m_in_valid = 0;
        @(negedge clk);
        check("rst2_out_valid", m_out_valid, 0);
        check("rst2_out_data", m_out_data, 0);
        check("rst2_in_ready", m_in_ready, 1);
        check("rst2_stall_cnt", m_stall_cnt, 0);
        repeat (4) step();

        check("m_queue_empty", mq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
